imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction memory from a byte stream before the core runs. It accepts a framed stream on a valid/ready byte interface and assembles little-endian 32-bit words. It writes each word to the instruction memory write port, checks a checksum, then releases the core from reset. It drives the write side of the instruction memory, which the core only reads.

## Interface
Parameters:
- DEPTH_WORDS, 32, instruction memory depth in words; legal frame lengths are 1..DEPTH_WORDS.
- ADDR_W, 5, width of imem_addr (clog2(DEPTH_WORDS)).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; a transfer occurs on rx_valid && rx_ready at posedge clk.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  ADDR_W  word index being written.
- imem_wdata  out  32  assembled word.
- core_reset  out  1  active-high reset to the core; high until a good frame completes.
- load_done  out  1  sticky: a frame loaded and verified.
- load_error  out  1  sticky: last frame rejected.
- words_loaded  out  ADDR_W+1  words written in the current or last frame.

## Operation
- Frame format: header 8'hA5, length byte N (words), 4·N data bytes (LSB first per word), then checksum byte. The checksum is the XOR of all 4·N data bytes.
- States: IDLE, LEN, DATA, WRITE, CHK, DONE.
- IDLE: rx_ready=1. A byte other than 8'hA5 is discarded. An 8'hA5 byte does the following, then goes to LEN:
  - clears load_error, words_loaded, byte counter and XOR accumulator.
- LEN: rx_ready=1. N is latched on acceptance.
  - If N==0 or N>DEPTH_WORDS: set load_error and return to IDLE.
  - Otherwise go to DATA.
- DATA: rx_ready=1.
  - Each accepted byte is shifted into word bits [8k+7:8k], where k is the 2-bit byte counter.
  - Each accepted byte is also XORed into the accumulator.
  - On the 4th byte (k==3), go to WRITE.
- WRITE: rx_ready=0; imem_we=1 with imem_addr=words_loaded[ADDR_W-1:0] and imem_wdata=the assembled word. words_loaded increments at the end of the cycle.
  - If the new count == N, go to CHK; otherwise go to DATA.
- CHK: rx_ready=1. The accepted byte is compared with the accumulator.
  - Match: go to DONE.
  - Mismatch: set load_error and go to IDLE; core_reset stays 1.
- DONE: rx_ready=0, load_done=1, core_reset=0. Stays here until reset; further bytes are not accepted.
- Arithmetic: the byte counter wraps 3→0. words_loaded never exceeds N. imem_addr never exceeds DEPTH_WORDS-1.
- imem_wdata, imem_addr hold their last values when imem_we=0.

## Timing
- Reset values:
  - state=IDLE, rx_ready=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, load_done=0, load_error=0, words_loaded=0.
- Write latency: 4th byte of a word accepted in cycle n → imem_we=1 in cycle n+1. The next data byte can be accepted no earlier than cycle n+2.
- Completion latency: checksum accepted in cycle m → load_done=1 and core_reset=0 from cycle m+1.
- Error latency: load_error=1 from the cycle after the offending byte is accepted.
- Gaps in rx_valid are allowed in any state. No state advances without a transfer, except WRITE, which always lasts exactly one cycle.
- Reset mid-frame (any state, including DONE) returns immediately to the reset values and asserts core_reset. Words already written stay in memory; the next frame overwrites from address 0.
- rx_ready is a function of state only, with no combinational path from rx_valid.

## Structure
- Shared package: the header constant HDR_BYTE=8'hA5 and the state enum typedef.
- One natural sub-module: imem_loader_word_asm, which holds the byte counter, shift/assemble register and XOR accumulator. It has clear and byte-strobe inputs, and word_ready, word and xor outputs.
- The FSM and the output registers live in imem_loader.

## Test plan
- Reset → rx_ready=1, imem_we=0, core_reset=1, load_done=0, load_error=0, words_loaded=0.
- Good frame A5 02 13 00 00 00 93 00 10 00 90, then expect:
  - writes addr0=32'h00000013 and addr1=32'h00100093;
  - load_done=1 and core_reset=0 one cycle after the 90 byte;
  - rx_ready=0 afterwards.
- The same frame with checksum 91 → load_error=1, load_done=0, core_reset=1. A following correct frame clears load_error on its A5 and completes normally.
- Length 00, and separately length 21 (33) → load_error=1, no imem_we, back in IDLE.
- Bytes 00 FF 5A before the header are ignored.
  - Random rx_valid gaps inside words give the same written words.
  - rx_ready=0 in each WRITE cycle, and a byte held on rx_valid there is taken the next cycle.
- Reset asserted after 6 data bytes of an N=2 frame → immediate reset values, no further imem_we, core_reset=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
package imem_loader_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_e;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler: byte-lane counter, shift/assemble register and
// running XOR of every accepted data byte.
module imem_loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o,
  output logic [7:0]  xor_o
);

  logic [1:0]  k_q, k_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] merged;

  // word_o already contains the byte being strobed, so the full word is
  // available in the same cycle its 4th byte is accepted.
  always_comb begin
    merged = word_q;
    merged[{k_q, 3'b000} +: 8] = byte_i;
  end

  always_comb begin
    k_d    = k_q;
    word_d = word_q;
    xor_d  = xor_q;
    if (clear_i) begin
      k_d    = 2'd0;
      word_d = 32'd0;
      xor_d  = 8'd0;
    end else if (byte_vld_i) begin
      k_d    = k_q + 2'd1;
      word_d = merged;
      xor_d  = xor_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= 2'd0;
      word_q <= 32'd0;
      xor_q  <= 8'd0;
    end else begin
      k_q    <= k_d;
      word_q <= word_d;
      xor_q  <= xor_d;
    end
  end

  assign word_ready_o = byte_vld_i && (k_q == 2'd3);
  assign word_o       = merged;
  assign xor_o        = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes instruction memory, verifies the
// XOR checksum and releases the core from reset on a good frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [8:0] DEPTH_L = 9'(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   words_loaded_q, wl_inc;
  logic              load_error_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;

  logic        acc, hdr_acc, len_bad, word_ready, data_vld;
  logic [31:0] asm_word;
  logic [7:0]  asm_xor;

  assign acc      = rx_valid && rx_ready;
  assign hdr_acc  = (state_q == S_IDLE) && acc && (rx_data == HDR_BYTE);
  assign len_bad  = (rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH_L);
  assign data_vld = (state_q == S_DATA) && acc;
  assign wl_inc   = words_loaded_q + (ADDR_W + 1)'(1);

  imem_loader_word_asm u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (hdr_acc),
    .byte_vld_i  (data_vld),
    .byte_i      (rx_data),
    .word_ready_o(word_ready),
    .word_o      (asm_word),
    .xor_o       (asm_xor)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hdr_acc) state_d = S_LEN;
      S_LEN:   if (acc) state_d = len_bad ? S_IDLE : S_DATA;
      S_DATA:  if (word_ready) state_d = S_WRITE;
      S_WRITE: state_d = (wl_inc == len_q) ? S_CHK : S_DATA;
      S_CHK:   if (acc) state_d = (rx_data == asm_xor) ? S_DONE : S_IDLE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status and handshake depend on state only, never on rx_valid.
  always_comb begin
    rx_ready   = 1'b0;
    imem_we    = 1'b0;
    load_done  = 1'b0;
    core_reset = 1'b1;
    case (state_q)
      S_IDLE, S_LEN, S_DATA, S_CHK: rx_ready = 1'b1;
      S_WRITE: imem_we = 1'b1;
      S_DONE: begin
        load_done  = 1'b1;
        core_reset = 1'b0;
      end
      default: ;
    endcase
  end

  // Address and data are captured with the 4th byte so they are valid during
  // WRITE and hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q          <= '0;
      words_loaded_q <= '0;
      load_error_q   <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= 32'd0;
    end else begin
      if (hdr_acc) begin
        load_error_q   <= 1'b0;
        words_loaded_q <= '0;
      end
      if ((state_q == S_LEN) && acc) begin
        len_q <= rx_data[ADDR_W:0];
        if (len_bad) load_error_q <= 1'b1;
      end
      if (word_ready) begin
        imem_addr_q  <= words_loaded_q[ADDR_W-1:0];
        imem_wdata_q <= asm_word;
      end
      if (state_q == S_WRITE) words_loaded_q <= wl_inc;
      if ((state_q == S_CHK) && acc && (rx_data != asm_xor)) load_error_q <= 1'b1;
    end
  end

  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write scoreboard plus status checks.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready, imem_we, core_reset, load_done, load_error;
  logic [4:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [5:0] words_loaded;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [36:0] exp_q[$];

  imem_loader #(.DEPTH_WORDS(32), .ADDR_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e[36:32]));
        check("wr_data", imem_wdata, e[31:0]);
        check("rx_ready_in_write", 32'(rx_ready), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [7:0] b, output int waited);
    int t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    if (!rx_ready) begin
      chk_cnt++;
      $display("FAIL send_timeout: got rx_ready 0 expected 1 for byte %h", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$], input bit gaps);
    int w;
    for (int j = 0; j < bs.size(); j++) begin
      send(bs[j], w);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      else if (j + 1 >= 6 && ((j + 1 - 2) % 4) == 0 && j + 1 < bs.size()) begin
        // Next byte follows a write: it must wait exactly the one WRITE cycle.
        logic [7:0] nb;
        nb = bs[j + 1];
        send(nb, w);
        check("held_byte_wait", 32'(w), 32'd1);
        j++;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_rx_ready"},     32'(rx_ready),     32'd1);
    check({tag, "_imem_we"},      32'(imem_we),      32'd0);
    check({tag, "_core_reset"},   32'(core_reset),   32'd1);
    check({tag, "_load_done"},    32'(load_done),    32'd0);
    check({tag, "_load_error"},   32'(load_error),   32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    check({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
    check({tag, "_imem_wdata"},   imem_wdata,        32'd0);
  endtask

  initial begin
    logic [7:0] bs[$];
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Leading garbage, then a frame with a bad checksum, sent with gaps.
    bs = '{8'h00, 8'hFF, 8'h5A};
    send_bytes(bs, 1'b1);
    check("garbage_words", 32'(words_loaded), 32'd0);
    exp_q.push_back({5'd0, 32'h00000013});
    exp_q.push_back({5'd1, 32'h00100093});
    bs = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
    send_bytes(bs, 1'b1);
    check("badcs_load_error", 32'(load_error), 32'd1);
    check("badcs_load_done",  32'(load_done),  32'd0);
    check("badcs_core_reset", 32'(core_reset), 32'd1);
    check("badcs_words",      32'(words_loaded), 32'd2);
    check("badcs_rx_ready",   32'(rx_ready),   32'd1);

    // Length 0: header clears the sticky error, then length sets it again.
    bs = '{8'hA5};
    send_bytes(bs, 1'b0);
    check("hdr_clears_error", 32'(load_error), 32'd0);
    check("hdr_clears_words", 32'(words_loaded), 32'd0);
    bs = '{8'h00};
    send_bytes(bs, 1'b0);
    check("len0_error",    32'(load_error), 32'd1);
    check("len0_rx_ready", 32'(rx_ready),   32'd1);

    // Length 33 exceeds the memory depth.
    bs = '{8'hA5, 8'h21};
    send_bytes(bs, 1'b0);
    check("len33_error",    32'(load_error), 32'd1);
    check("len33_rx_ready", 32'(rx_ready),   32'd1);
    check("len33_words",    32'(words_loaded), 32'd0);

    // Good frame, back to back.
    exp_q.push_back({5'd0, 32'h00000013});
    exp_q.push_back({5'd1, 32'h00100093});
    bs = '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_bytes(bs, 1'b0);
    check("good_load_done",  32'(load_done),  32'd1);
    check("good_core_reset", 32'(core_reset), 32'd0);
    check("good_load_error", 32'(load_error), 32'd0);
    check("good_rx_ready",   32'(rx_ready),   32'd0);
    check("good_words",      32'(words_loaded), 32'd2);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check("done_rx_ready",  32'(rx_ready),  32'd0);
    check("done_load_done", 32'(load_done), 32'd1);

    // Reset during a frame after 6 data bytes.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back({5'd0, 32'h04030201});
    bs = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_bytes(bs, 1'b0);
    check("mid_words", 32'(words_loaded), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bs = '{8'h07, 8'h08};
    send_bytes(bs, 1'b0);
    check("post_reset_core_reset", 32'(core_reset), 32'd1);
    check("post_reset_words",      32'(words_loaded), 32'd0);

    // Next frame overwrites from address 0.
    exp_q.push_back({5'd0, 32'hEFBEADDE});
    bs = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_bytes(bs, 1'b1);
    check("n1_load_done",  32'(load_done),  32'd1);
    check("n1_core_reset", 32'(core_reset), 32'd0);
    check("n1_words",      32'(words_loaded), 32'd1);

    repeat (3) @(negedge clk);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
